// File: rtl/pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_ctrl
//
// Double-buffer scheduler for a pair of caches sitting behind a processor/fill
// mux. While the processor consumes one cache, the built-in fill engine streams
// source words into the other one. Once both sides have finished, the caches
// are swapped and the processor is told that a fresh buffer is ready.
//
// Run sequence:
//   IDLE  -> PRIME : fill the first buffer (sel=1, fill side is cache1)
//   PRIME -> SWAP  : one-cycle hand-over, sel toggles, proc_start pulses
//   SWAP  -> RUN   : processor works; the next buffer fills on the other side
//   RUN   -> SWAP  : processor done and fill done, buffers still outstanding
//   RUN   -> FIN   : processor has consumed the last buffer
//   FIN   -> IDLE  : done pulses for one cycle
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle run request, honoured only in IDLE
//   n_bufs      number of buffers to fill and process, captured on start
//   sel         mux select (0: proc->cache1, fill->cache2; 1: the reverse)
//   proc_start  one-cycle pulse, a freshly filled buffer is on the proc side
//   proc_done   one-cycle pulse from the processor, current buffer finished
//   src_valid   source has a word available
//   src_ready   fill engine accepts a word this cycle
//   fill_Addr   write address on the fill-side cache
//   fill_WE     write enable on the fill-side cache
//   busy        run in progress (PRIME, SWAP, RUN)
//   done        one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module pingpong_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int FILL_WORDS = 256,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_bufs,
  output logic              sel,
  output logic              proc_start,
  input  logic              proc_done,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [ADDR_W-1:0] fill_Addr,
  output logic              fill_WE,
  output logic              busy,
  output logic              done
);

  // The word counter is one bit wider than the address so that it can hold
  // FILL_WORDS itself, even when FILL_WORDS equals 2^ADDR_W.
  localparam int WC_W = ADDR_W + 1;

  localparam logic [WC_W-1:0]  FILL_END  = WC_W'(FILL_WORDS);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(FILL_WORDS - 1);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SWAP,
    RUN,
    FIN
  } state_t;

  state_t            state;
  logic [WC_W-1:0]   word_cnt;    // words written into the current fill buffer
  logic [CNT_W-1:0]  n_bufs_r;    // run length captured on start
  logic [CNT_W-1:0]  filled_cnt;  // buffers completely filled so far
  logic [CNT_W-1:0]  processed;   // proc_done pulses seen in RUN
  logic              pdone;       // processor finished the current buffer

  logic              fill_needed;
  logic              fill_active;
  logic              last_beat;
  logic              run_fill_fin;
  logic              proc_seen;
  logic [CNT_W-1:0]  processed_nxt;
  logic              run_exit;
  logic              all_processed;
  logic              go_swap;
  logic              go_fin_run;

  // ---------------------------------------------------------------------------
  // Fill engine and transition conditions, all derived from registered state
  // plus the current-cycle handshakes.
  // ---------------------------------------------------------------------------
  // NOTE: every signal in this block is assigned on every path through it, so
  // no storage is implied and the block stays purely combinational.
  always_comb begin
    fill_needed   = (filled_cnt < n_bufs_r);
    fill_active   = (state == PRIME) || ((state == RUN) && fill_needed);
    src_ready     = fill_active && (word_cnt < FILL_END);
    fill_WE       = src_valid && src_ready;

    // The beat that writes FILL_WORDS-1 completes the buffer; acting on it
    // directly lets the swap follow the last write without a dead cycle.
    last_beat     = fill_WE && (word_cnt == LAST_WORD);

    // In RUN the fill side is finished if nothing had to be filled, the
    // buffer was completed earlier, or it completes on this very beat.
    run_fill_fin  = !fill_needed || (word_cnt == FILL_END) || last_beat;

    // A proc_done in the same cycle counts as if the flag were already set,
    // so a coincident final beat and proc_done swap on the next edge.
    proc_seen     = (state == RUN) && proc_done;
    processed_nxt = proc_seen ? (processed + CNT_ONE) : processed;
    run_exit      = (state == RUN) && (pdone || proc_seen) && run_fill_fin;
    all_processed = (processed_nxt == n_bufs_r);

    go_swap       = ((state == PRIME) && last_beat) || (run_exit && !all_processed);
    go_fin_run    = run_exit && all_processed;
  end

  assign fill_Addr = word_cnt[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Sequencer: state, counters and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state here updates with non-blocking assignments, so every
  // right-hand side reads the pre-edge value and later assignments in the
  // block cleanly override earlier defaults for the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      proc_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_cnt   <= '0;
      n_bufs_r   <= '0;
      filled_cnt <= '0;
      processed  <= '0;
      pdone      <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle.
      proc_start <= 1'b0;
      done       <= 1'b0;

      if (fill_WE) begin
        word_cnt <= word_cnt + WC_ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (n_bufs == '0) begin
              // Empty run: report completion without touching sel or busy.
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= PRIME;
              sel        <= 1'b1;
              busy       <= 1'b1;
              n_bufs_r   <= n_bufs;
              filled_cnt <= '0;
              processed  <= '0;
              pdone      <= 1'b0;
              word_cnt   <= '0;
            end
          end
        end

        PRIME: begin
          // Leaves through go_swap on the final beat.
        end

        SWAP: begin
          state <= RUN;
        end

        RUN: begin
          if (proc_done) begin
            processed <= processed_nxt;
            pdone     <= 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Hand-over: the new sel and proc_start appear together in SWAP, and the
      // fill side restarts from address 0 for the next buffer.
      if (go_swap) begin
        state      <= SWAP;
        sel        <= ~sel;
        proc_start <= 1'b1;
        filled_cnt <= filled_cnt + CNT_ONE;
        word_cnt   <= '0;
        pdone      <= 1'b0;
      end

      // Last buffer consumed: sel is deliberately left where it is.
      if (go_fin_run) begin
        state    <= FIN;
        done     <= 1'b1;
        busy     <= 1'b0;
        pdone    <= 1'b0;
        word_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants of the sequencing.
  // ---------------------------------------------------------------------------
  a_we_in_range : assert property (@(posedge clk) disable iff (rst)
    fill_WE |-> (word_cnt < FILL_END));

  a_start_in_swap : assert property (@(posedge clk) disable iff (rst)
    proc_start |-> (state == SWAP));

  a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
    done |-> !busy);

endmodule

// File: tb/tb_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pingpong_ctrl with FILL_WORDS=4.
// A behavioural model tracks the run as "buffers filled / processed" and
// "words written into the current buffer"; every cycle all outputs are
// compared against it. Per-run totals (write beats, proc_start pulses, done
// pulses) are also checked against the arithmetic the run implies.
// -----------------------------------------------------------------------------
module tb_pingpong_ctrl;

  localparam int ADDR_W = 16;
  localparam int FW     = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  n_bufs;
  logic              sel;
  logic              proc_start;
  logic              proc_done;
  logic              src_valid;
  logic              src_ready;
  logic [ADDR_W-1:0] fill_Addr;
  logic              fill_WE;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pingpong_ctrl #(
    .ADDR_W     (ADDR_W),
    .FILL_WORDS (FW),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_bufs     (n_bufs),
    .sel        (sel),
    .proc_start (proc_start),
    .proc_done  (proc_done),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .fill_Addr  (fill_Addr),
    .fill_WE    (fill_WE),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a run is "prime the first buffer, then alternate
  // hand-over and (process one buffer while filling the next)".
  // ---------------------------------------------------------------------------
  bit m_running;    // a run is in progress (busy)
  bit m_priming;    // first buffer still being filled
  bit m_swap_now;   // this cycle is the hand-over cycle
  bit m_done_now;   // this cycle is the completion cycle
  bit m_pflag;      // processor reported the current buffer finished
  bit m_sel;
  int m_words;      // words written into the buffer being filled
  int m_filled;     // buffers fully written
  int m_processed;  // buffers the processor has finished
  int m_nbufs;

  // Observed per-run totals.
  int n_we, n_ps, n_dn;

  function automatic bit m_in_run();
    return m_running && !m_priming && !m_swap_now;
  endfunction

  function automatic bit m_ready();
    bit active;
    active = m_running && !m_swap_now && (m_priming || (m_filled < m_nbufs));
    return active && (m_words < FW);
  endfunction

  task automatic model_reset();
    m_running = 0; m_priming = 0; m_swap_now = 0; m_done_now = 0; m_pflag = 0;
    m_sel = 0; m_words = 0; m_filled = 0; m_processed = 0; m_nbufs = 0;
  endtask

  task automatic model_handover();
    m_swap_now = 1;
    m_sel      = !m_sel;
    m_filled++;
    m_words    = 0;
    m_pflag    = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input int n, input bit v, input bit pd);
    bit beat;
    beat = m_ready() && v;
    if (r) begin
      model_reset();
    end else if (m_done_now) begin
      m_done_now = 0;
    end else if (!m_running) begin
      if (s) begin
        if (n == 0) begin
          m_done_now = 1;
        end else begin
          m_running = 1; m_priming = 1; m_sel = 1; m_words = 0;
          m_filled = 0; m_processed = 0; m_nbufs = n; m_pflag = 0;
        end
      end
    end else if (m_swap_now) begin
      m_swap_now = 0;
    end else if (m_priming) begin
      if (beat) m_words++;
      if (m_words == FW) begin
        m_priming = 0;
        model_handover();
      end
    end else begin
      if (beat) m_words++;
      if (pd) begin
        m_processed++;
        m_pflag = 1;
      end
      if (m_pflag && ((m_filled >= m_nbufs) || (m_words == FW))) begin
        if (m_processed == m_nbufs) begin
          m_running  = 0;
          m_done_now = 1;
          m_pflag    = 0;
          m_words    = 0;
        end else begin
          model_handover();
        end
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs
  // shortly after, advance the model, wait for the next falling edge.
  task automatic cycle(input bit r, input bit s, input int n, input bit v, input bit pd,
                       input bit do_chk);
    rst       = r;
    start     = s;
    n_bufs    = n[CNT_W-1:0];
    src_valid = v;
    proc_done = pd;
    #1;
    if (do_chk) begin
      check("sel",        sel,        m_sel);
      check("proc_start", proc_start, m_swap_now);
      check("busy",       busy,       m_running);
      check("done",       done,       m_done_now);
      check("src_ready",  src_ready,  m_ready());
      check("fill_WE",    fill_WE,    m_ready() && v);
      check("fill_Addr",  fill_Addr,  m_words);
    end
    if (fill_WE === 1'b1)    n_we++;
    if (proc_start === 1'b1) n_ps++;
    if (done === 1'b1)       n_dn++;
    model_step(r, s, n, v, pd);
    @(negedge clk);
  endtask

  // One run. vmode: 0 = src_valid always high, 1 = random, 2 = 1,0,0 pattern.
  // pdelay: cycles from proc_start to proc_done (<=0 means random 1..8).
  // misuse_at / abort_at: cycle index of an extra start / a reset (-1 = none).
  task automatic run_job(input int n, input int vmode, input int pdelay,
                         input int misuse_at, input int abort_at);
    int  timer;
    int  k;
    int  budget;
    bit  v, pd, s, r;
    timer  = -1;
    budget = 60 + n * 60;
    n_we = 0; n_ps = 0; n_dn = 0;
    cycle(0, 1, n, ($urandom_range(0, 1) == 1), 0, 1);
    k = 1;
    while ((m_running || m_done_now) && (k < budget)) begin
      case (vmode)
        0:       v = 1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = ((k % 3) == 0);
      endcase
      if (m_swap_now) timer = (pdelay > 0) ? pdelay : int'($urandom_range(1, 8));
      else if (timer > 0) timer--;
      pd = (timer == 0);
      if (pd) timer = -1;
      // Stray proc_done outside RUN must be ignored.
      if (!pd && (vmode == 1) && !m_in_run() && ($urandom_range(0, 5) == 0)) pd = 1;
      s = (k == misuse_at);
      r = (k == abort_at);
      cycle(r, s, s ? 7 : n, v, pd, 1);
      k++;
    end
    check("run_terminated", (k < budget), 1);
    if (abort_at < 0) begin
      check("write_beats",      n_we, n * FW);
      check("proc_start_count", n_ps, n);
      check("done_count",       n_dn, 1);
    end
    // Idle cycle: outputs settle (and after an abort, everything reads 0).
    cycle(0, 0, 0, 1, 0, 1);
  endtask

  initial begin
    rst = 1; start = 0; n_bufs = '0; src_valid = 0; proc_done = 0;
    model_reset();
    @(negedge clk);

    // Reset held two cycles with random inputs.
    cycle(1, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 255)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 0);
    cycle(1, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 255)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Single buffer, proc_done 10 cycles after proc_start.
    run_job(1, 0, 10, -1, -1);
    // Three buffers, proc_done 20 cycles after each proc_start.
    run_job(3, 0, 20, -1, -1);
    // proc_done while the fill is at word 1.
    run_job(2, 0, 2, -1, -1);
    // proc_done coincides with the final fill beat.
    run_job(2, 0, 4, -1, -1);
    // Source gaps.
    run_job(2, 2, 3, -1, -1);
    // start while busy: once in PRIME, once in RUN.
    run_job(2, 0, 5, 2, -1);
    run_job(2, 0, 5, 8, -1);
    // Reset in the middle of RUN.
    run_job(3, 0, 6, -1, 9);
    // Empty run.
    run_job(0, 0, 1, -1, -1);
    // Randomized runs.
    for (int i = 0; i < 12; i++) begin
      run_job(int'($urandom_range(0, 5)), (i % 3 == 2) ? 2 : 1, 0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
